pulse_train_sequencer: RTL and testbench

Sequences one pulse-train burst through a signal generator (noise, LFM, etc.) sharing the `SIGNAL_TYPE` / `T_IMPULSE` / `SIGN_START_GEN` / `OUT_REG_READY` / `SIGN_START_CALC` / `SIGN_STOP_CALC` handshake. It latches a burst configuration, issues one start strobe per pulse at a fixed repetition period, and tracks generator acknowledge and completion. It reports burst progress, completion and errors to the control/host interface. It sits between the control registers and the generator bank, upstream of the output register.

---
 rtl/pulse_train_sequencer.sv | 123 ++++++++++++
 tb/tb_pulse_train_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_sequencer.sv
// pulse_train_sequencer: latches a burst config and strobes a signal generator once per period.
// Define PULSE_SEQ_ACK_TIMEOUT_EN to build the generator-acknowledge timeout.
module pulse_train_sequencer #(
  parameter int PERIOD_W    = 16,
  parameter int NPULSE_W    = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                ABORT,
  input  logic [1:0]          CFG_SIGNAL_TYPE,
  input  logic [9:0]          CFG_T_IMPULSE,
  input  logic [NPULSE_W-1:0] CFG_NUM_PULSES,
  input  logic [PERIOD_W-1:0] CFG_PERIOD,
  input  logic                OUT_REG_READY,
  input  logic                GEN_START_CALC,
  input  logic                GEN_STOP_CALC,
  output logic [1:0]          SIGNAL_TYPE,
  output logic [9:0]          T_IMPULSE,
  output logic                SIGN_START_GEN,
  output logic                GEN_RESET,
  output logic                BUSY,
  output logic                DONE,
  output logic [NPULSE_W-1:0] PULSE_IDX,
  output logic [1:0]          ERR_CODE
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_ACK, RUN, FINISH} state_t;
  state_t state, state_d;
  logic [NPULSE_W-1:0] num_pulses, num_d, idx_d;
  logic [PERIOD_W-1:0] period, period_d, pcnt, pcnt_d;
  logic [1:0] type_d, err_d;
  logic [9:0] t_d;
  logic strobe_d, gen_rst_d, timeout;
`ifdef PULSE_SEQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] ack_tmr;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ack_tmr <= '0;
    else ack_tmr <= (state == WAIT_ACK) ? ack_tmr + 1'b1 : '0;
  assign timeout = ack_tmr == TW'(ACK_TIMEOUT);
`else
  assign timeout = ACK_TIMEOUT < 0;
`endif
  always_comb begin
    state_d   = state;
    type_d    = SIGNAL_TYPE;
    t_d       = T_IMPULSE;
    num_d     = num_pulses;
    period_d  = period;
    idx_d     = PULSE_IDX;
    err_d     = ERR_CODE;
    strobe_d  = 1'b0;
    gen_rst_d = 1'b0;
    pcnt_d    = (pcnt != '0) ? pcnt - 1'b1 : pcnt;
    case (state)
      IDLE: if (START && !ABORT) begin
        type_d   = CFG_SIGNAL_TYPE;
        t_d      = CFG_T_IMPULSE;
        num_d    = CFG_NUM_PULSES;
        period_d = CFG_PERIOD;
        idx_d    = '0;
        err_d    = 2'd0;
        pcnt_d   = '0;
        state_d  = (CFG_NUM_PULSES == '0) ? FINISH : ARM;
      end
      // Load period-1 so the next strobe lands exactly PERIOD cycles after this one.
      ARM: if (OUT_REG_READY && pcnt == '0) begin
        strobe_d = 1'b1;
        pcnt_d   = period - PERIOD_W'(period != '0);
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: if (GEN_START_CALC) state_d = RUN;
      else if (timeout) begin
        err_d     = 2'd2;
        gen_rst_d = 1'b1;
        state_d   = IDLE;
      end
      RUN: if (GEN_STOP_CALC) begin
        idx_d   = PULSE_IDX + 1'b1;
        state_d = (idx_d == num_pulses) ? FINISH : ARM;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state == WAIT_ACK || state == RUN) && pcnt == '0 && period != '0 && err_d == 2'd0) err_d = 2'd1;
    if (ABORT && state != IDLE) begin
      state_d   = IDLE;
      err_d     = 2'd3;
      gen_rst_d = 1'b1;
      strobe_d  = 1'b0;
      idx_d     = PULSE_IDX;
    end
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state          <= IDLE;
      num_pulses     <= '0;
      period         <= '0;
      pcnt           <= '0;
      SIGNAL_TYPE    <= '0;
      T_IMPULSE      <= '0;
      SIGN_START_GEN <= 1'b0;
      GEN_RESET      <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PULSE_IDX      <= '0;
      ERR_CODE       <= '0;
    end else begin
      state          <= state_d;
      num_pulses     <= num_d;
      period         <= period_d;
      pcnt           <= pcnt_d;
      SIGNAL_TYPE    <= type_d;
      T_IMPULSE      <= t_d;
      SIGN_START_GEN <= strobe_d;
      GEN_RESET      <= gen_rst_d;
      BUSY           <= state != IDLE || state_d != IDLE;
      DONE           <= state == FINISH && !ABORT;
      PULSE_IDX      <= idx_d;
      ERR_CODE       <= err_d;
    end
endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb_pulse_train_sequencer: randomized bursts against a closed-form timing model with a reactive generator.
module tb_pulse_train_sequencer;
  logic clk, rst_n, start, abort, ready, gen_start_calc, gen_stop_calc;
  logic [1:0] cfg_type, sig_type, err_code;
  logic [9:0] cfg_t, t_imp;
  logic [7:0] cfg_num, pulse_idx;
  logic [15:0] cfg_period;
  logic strobe, gen_reset, busy, done;
  int tests, fails, cyc, ack_at, stop_at, ack_lat, dur;
  bit gen_ack_en;
  int strobe_q[$], done_q[$], grst_q[$];

  pulse_train_sequencer dut (
    .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort),
    .CFG_SIGNAL_TYPE(cfg_type), .CFG_T_IMPULSE(cfg_t), .CFG_NUM_PULSES(cfg_num), .CFG_PERIOD(cfg_period),
    .OUT_REG_READY(ready), .GEN_START_CALC(gen_start_calc), .GEN_STOP_CALC(gen_stop_calc),
    .SIGNAL_TYPE(sig_type), .T_IMPULSE(t_imp), .SIGN_START_GEN(strobe), .GEN_RESET(gen_reset),
    .BUSY(busy), .DONE(done), .PULSE_IDX(pulse_idx), .ERR_CODE(err_code)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One cycle: observe outputs mid-cycle, then drive the generator model for this cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (strobe) begin
      strobe_q.push_back(cyc);
      if (gen_ack_en) begin ack_at = cyc + ack_lat; stop_at = cyc + dur; end
    end
    if (done) done_q.push_back(cyc);
    if (gen_reset) begin grst_q.push_back(cyc); ack_at = -1; stop_at = -1; end
    gen_start_calc = (cyc == ack_at);
    gen_stop_calc  = (cyc == stop_at);
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; abort = 0; ready = 1; cfg_type = 0; cfg_t = 0; cfg_num = 0; cfg_period = 0;
    gen_start_calc = 0; gen_stop_calc = 0;
    repeat (3) tick();
    tests++;
    if ({sig_type, t_imp, strobe, gen_reset, busy, done, pulse_idx, err_code} !== 26'd0) begin
      fails++; $display("FAIL reset_hold: outputs=%h want 0", {sig_type, t_imp, strobe, gen_reset, busy, done, pulse_idx, err_code});
    end
    rst_n = 1;
    repeat (2) tick();
    tests++;
    if ({sig_type, t_imp, strobe, gen_reset, busy, done, pulse_idx, err_code} !== 26'd0) begin
      fails++; $display("FAIL reset_release: outputs=%h want 0", {sig_type, t_imp, strobe, gen_reset, busy, done, pulse_idx, err_code});
    end
  endtask

  // Expected: strobe k at c0+2+k*max(P,D+2); idx k+1 from stop_k+1; DONE at last stop+2; overrun iff P!=0 and D+2>P.
  task automatic run_burst(input int n, input int p, input int l, input int d);
    int sp, c0, limit, bad_at, exp_idx, exp_err, exp_done, bad_k;
    logic [1:0] ty;
    logic [9:0] ti;
    sp = (p > d + 2) ? p : d + 2;
    exp_err = (p != 0 && d + 2 > p) ? 1 : 0;
    exp_done = 2 + (n - 1) * sp + d + 2;
    ack_lat = l; dur = d; gen_ack_en = 1;
    strobe_q.delete(); done_q.delete();
    ty = 2'($urandom); ti = 10'($urandom);
    cfg_num = 8'(n); cfg_period = 16'(p); cfg_type = ty; cfg_t = ti;
    start = 1; c0 = cyc;
    tick();
    start = 0; cfg_type = ~ty; cfg_t = ~ti; cfg_num = 8'($urandom); cfg_period = 16'($urandom);
    tests++;
    if (busy !== 1'b1 || err_code !== 2'd0) begin
      fails++; $display("FAIL burst_start: busy=%0b err=%0d want busy=1 err=0", busy, err_code);
    end
    limit = c0 + 2 + n * sp + d + 10; bad_at = -1;
    while (done_q.size() == 0 && cyc < limit) begin
      tick();
      exp_idx = 0;
      for (int k = 0; k < n; k++) if (c0 + 2 + k * sp + d + 1 <= cyc) exp_idx++;
      if (pulse_idx !== 8'(exp_idx) && bad_at < 0) bad_at = cyc - c0;
    end
    tests++;
    if (bad_at >= 0) begin
      fails++; $display("FAIL burst_idx: PULSE_IDX wrong at cycle +%0d (n=%0d p=%0d d=%0d)", bad_at, n, p, d);
    end
    tests++;
    if (strobe_q.size() != n) begin
      fails++; $display("FAIL burst_strobe_count: got %0d want %0d (p=%0d d=%0d)", strobe_q.size(), n, p, d);
    end
    bad_k = -1;
    for (int k = 0; k < strobe_q.size() && k < n; k++) if (strobe_q[k] != c0 + 2 + k * sp && bad_k < 0) bad_k = k;
    tests++;
    if (bad_k >= 0) begin
      fails++; $display("FAIL burst_strobe_time: strobe %0d at +%0d want +%0d", bad_k, strobe_q[bad_k] - c0, 2 + bad_k * sp);
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != c0 + exp_done) begin
      fails++; $display("FAIL burst_done: count=%0d at +%0d want 1 at +%0d", done_q.size(), done_q.size() ? done_q[0] - c0 : -1, exp_done);
    end
    tests++;
    if (err_code !== 2'(exp_err) || busy !== 1'b1) begin
      fails++; $display("FAIL burst_err: err=%0d busy=%0b want err=%0d busy=1", err_code, busy, exp_err);
    end
    tests++;
    if (sig_type !== ty || t_imp !== ti) begin
      fails++; $display("FAIL burst_latch: type=%0d t=%0d want type=%0d t=%0d", sig_type, t_imp, ty, ti);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL burst_idle: busy=%0b done=%0b want 0/0", busy, done);
    end
  endtask

  task automatic test_zero();
    strobe_q.delete(); done_q.delete();
    cfg_num = 0; cfg_period = 16'd5; start = 1;
    tick();
    start = 0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_c1: busy=%0b done=%0b want 1/0", busy, done); end
    tick();
    tests++;
    if (busy !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL zero_c2: busy=%0b done=%0b want 1/1", busy, done); end
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || strobe_q.size() != 0) begin
      fails++; $display("FAIL zero_c3: busy=%0b done=%0b strobes=%0d want 0/0/0", busy, done, strobe_q.size());
    end
  endtask

  task automatic test_ready();
    int lim;
    strobe_q.delete(); done_q.delete();
    ready = 0; cfg_num = 1; cfg_period = 0; ack_lat = 1; dur = 3; start = 1;
    tick();
    start = 0;
    repeat (100) tick();
    tests++;
    if (strobe_q.size() != 0 || busy !== 1'b1) begin
      fails++; $display("FAIL ready_hold: strobes=%0d busy=%0b want 0/1", strobe_q.size(), busy);
    end
    ready = 1;
    tick();
    tests++;
    if (strobe !== 1'b1) begin fails++; $display("FAIL ready_rise: strobe=%0b want 1", strobe); end
    lim = cyc + 20;
    while (done_q.size() == 0 && cyc < lim) tick();
    tests++;
    if (done_q.size() != 1) begin fails++; $display("FAIL ready_done: done count=%0d want 1", done_q.size()); end
    repeat (2) tick();
  endtask

  task automatic test_ack_timeout();
    int lim, ts;
    strobe_q.delete(); done_q.delete(); grst_q.delete();
    gen_ack_en = 0; cfg_num = 1; cfg_period = 0; start = 1;
    tick();
    start = 0;
    lim = cyc + 5;
    while (strobe_q.size() == 0 && cyc < lim) tick();
    tests++;
    if (strobe_q.size() != 1) begin fails++; $display("FAIL noack_strobe: strobes=%0d want 1", strobe_q.size()); end
    ts = strobe_q.size() ? strobe_q[0] : cyc;
`ifdef PULSE_SEQ_ACK_TIMEOUT_EN
    lim = ts + 40;
    while (grst_q.size() == 0 && cyc < lim) tick();
    tests++;
    if (grst_q.size() != 1 || grst_q[0] != ts + 16) begin
      fails++; $display("FAIL noack_genreset: count=%0d at +%0d want 1 at +16", grst_q.size(), grst_q.size() ? grst_q[0] - ts : -1);
    end
    tests++;
    if (err_code !== 2'd2) begin fails++; $display("FAIL noack_err: err=%0d want 2", err_code); end
    tick();
    tests++;
    if (busy !== 1'b0 || done_q.size() != 0) begin
      fails++; $display("FAIL noack_idle: busy=%0b dones=%0d want 0/0", busy, done_q.size());
    end
`else
    repeat (60) tick();
    tests++;
    if (grst_q.size() != 0 || busy !== 1'b1 || err_code !== 2'd0) begin
      fails++; $display("FAIL noack_wait: genresets=%0d busy=%0b err=%0d want 0/1/0", grst_q.size(), busy, err_code);
    end
    abort = 1;
    tick();
    abort = 0;
    tests++;
    if (gen_reset !== 1'b1 || err_code !== 2'd3) begin
      fails++; $display("FAIL noack_abort: gen_reset=%0b err=%0d want 1/3", gen_reset, err_code);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || done_q.size() != 0) begin
      fails++; $display("FAIL noack_idle: busy=%0b dones=%0d want 0/0", busy, done_q.size());
    end
`endif
    gen_ack_en = 1;
  endtask

  task automatic test_abort();
    int c0;
    strobe_q.delete(); done_q.delete(); grst_q.delete();
    ack_lat = 1; dur = 20; cfg_num = 3; cfg_period = 16'd40; start = 1; c0 = cyc;
    tick();
    start = 0;
    while (cyc < c0 + 62) tick();
    tests++;
    if (pulse_idx !== 8'd1 || strobe_q.size() != 2 || gen_stop_calc !== 1'b1) begin
      fails++; $display("FAIL abort_setup: idx=%0d strobes=%0d stop=%0b want 1/2/1", pulse_idx, strobe_q.size(), gen_stop_calc);
    end
    abort = 1;
    tick();
    abort = 0;
    tests++;
    if (gen_reset !== 1'b1 || err_code !== 2'd3 || pulse_idx !== 8'd1) begin
      fails++; $display("FAIL abort_hit: gen_reset=%0b err=%0d idx=%0d want 1/3/1", gen_reset, err_code, pulse_idx);
    end
    repeat (4) tick();
    tests++;
    if (done_q.size() != 0 || busy !== 1'b0 || grst_q.size() != 1) begin
      fails++; $display("FAIL abort_after: dones=%0d busy=%0b genresets=%0d want 0/0/1", done_q.size(), busy, grst_q.size());
    end
    start = 1;
    tick();
    start = 0;
    tests++;
    if (err_code !== 2'd0 || busy !== 1'b1 || pulse_idx !== 8'd0) begin
      fails++; $display("FAIL abort_restart: err=%0d busy=%0b idx=%0d want 0/1/0", err_code, busy, pulse_idx);
    end
    abort = 1;
    tick();
    abort = 0;
    repeat (2) tick();
  endtask

  task automatic test_idle_abort();
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    tick();
    tests++;
    if (busy !== 1'b0 || err_code !== 2'd3 || strobe !== 1'b0) begin
      fails++; $display("FAIL idle_abort: busy=%0b err=%0d strobe=%0b want 0/3/0", busy, err_code, strobe);
    end
  endtask

  task automatic test_async_reset();
    strobe_q.delete(); done_q.delete(); grst_q.delete();
    ack_lat = 1; dur = 10; cfg_num = 2; cfg_period = 16'd30; start = 1;
    tick();
    start = 0;
    repeat (6) tick();
    #2 rst_n = 0;
    #1;
    tests++;
    if ({sig_type, t_imp, strobe, gen_reset, busy, done, pulse_idx, err_code} !== 26'd0) begin
      fails++; $display("FAIL async_reset: outputs=%h want 0", {sig_type, t_imp, strobe, gen_reset, busy, done, pulse_idx, err_code});
    end
    ack_at = -1; stop_at = -1;
    repeat (2) tick();
    rst_n = 1;
    repeat (10) tick();
    tests++;
    if (done_q.size() != 0 || grst_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL async_after: dones=%0d genresets=%0d busy=%0b want 0/0/0", done_q.size(), grst_q.size(), busy);
    end
  endtask

  task automatic test_random();
    int n, p, l, d;
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 5);
      p = $urandom_range(0, 50);
      l = $urandom_range(1, 3);
      d = $urandom_range(l + 1, 30);
      run_burst(n, p, l, d);
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; ack_at = -1; stop_at = -1; ack_lat = 1; dur = 20; gen_ack_en = 1;
    test_reset();
    run_burst(3, 40, 1, 20);
    test_zero();
    run_burst(3, 10, 1, 25);
    run_burst(2, 0, 2, 5);
    test_ready();
    test_ack_timeout();
    test_abort();
    test_idle_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
